// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: control-word bit positions,
// opcodes, MUL FSM states and operand-usage helpers.
package id_ex_stage_pkg;

  localparam int REG_DST    = 7;
  localparam int BRANCH     = 6;
  localparam int MEM_READ   = 5;
  localparam int MEM_TO_REG = 4;
  localparam int MEM_WRITE  = 3;
  localparam int ALU_SRC    = 2;
  localparam int REG_WRITE  = 1;
  localparam int JUMP       = 0;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_MUL  = 6'h02;
  localparam logic [5:0] OP_LDB  = 6'h10;
  localparam logic [5:0] OP_LDW  = 6'h11;
  localparam logic [5:0] OP_STB  = 6'h12;
  localparam logic [5:0] OP_STW  = 6'h13;
  localparam logic [5:0] OP_BEQ  = 6'h30;
  localparam logic [5:0] OP_JUMP = 6'h31;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Jumps take their target from the immediate, so rs is not a real read.
  function automatic logic uses_rs(input logic valid, input logic [7:0] ctrl);
    return valid & ~ctrl[JUMP];
  endfunction

  function automatic logic uses_rt(input logic valid, input logic [7:0] ctrl);
    return valid & (ctrl[REG_DST] | ctrl[MEM_WRITE] | (ctrl[BRANCH] & ~ctrl[JUMP]));
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: ID-side inputs, flush, EX-side outputs and stall.
// master drives the decode side; slave is the pipeline register itself.
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              id_valid;
  logic [5:0]        id_opcode;
  logic [7:0]        id_ctrl;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic [DATA_W-1:0] id_rs_val;
  logic [DATA_W-1:0] id_rt_val;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc;
  logic              flush;

  logic              ex_valid;
  logic [7:0]        ex_ctrl;
  logic [5:0]        ex_opcode;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_dest;
  logic [DATA_W-1:0] ex_rs_val;
  logic [DATA_W-1:0] ex_rt_val;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_pc;
  logic              ex_busy;
  logic              stall;

  modport master (
    output id_valid, id_opcode, id_ctrl, id_rs, id_rt, id_rd,
           id_rs_val, id_rt_val, id_imm, id_pc, flush,
    input  ex_valid, ex_ctrl, ex_opcode, ex_rs, ex_rt, ex_dest,
           ex_rs_val, ex_rt_val, ex_imm, ex_pc, ex_busy, stall
  );

  modport slave (
    input  id_valid, id_opcode, id_ctrl, id_rs, id_rt, id_rd,
           id_rs_val, id_rt_val, id_imm, id_pc, flush,
    output ex_valid, ex_ctrl, ex_opcode, ex_rs, ex_rt, ex_dest,
           ex_rs_val, ex_rt_val, ex_imm, ex_pc, ex_busy, stall
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use compare: a valid load in EX whose nonzero destination is read by
// the instruction in ID. Only meaningful while the MUL FSM is idle.
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             fsm_idle_i,
  input  logic             ex_valid_i,
  input  logic [7:0]       ex_ctrl_i,
  input  logic [REG_W-1:0] ex_dest_i,
  input  logic             id_valid_i,
  input  logic [7:0]       id_ctrl_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  output logic             load_use_o
);
  logic ex_is_load;
  logic rs_hit;
  logic rt_hit;

  assign ex_is_load = fsm_idle_i & ex_valid_i & ex_ctrl_i[MEM_READ] & (ex_dest_i != '0);
  assign rs_hit     = uses_rs(id_valid_i, id_ctrl_i) & (ex_dest_i == id_rs_i);
  assign rt_hit     = uses_rt(id_valid_i, id_ctrl_i) & (ex_dest_i == id_rt_i);
  assign load_use_o = ex_is_load & (rs_hit | rt_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, multi-cycle MUL
// occupancy of EX and branch/jump flush. stall is the only combinational output.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int MUL_CYCLES = 3
) (
  input  logic   clk,
  input  logic   reset,
  id_ex_if.slave bus
);
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              ex_valid_q;
  logic [7:0]        ex_ctrl_q;
  logic [5:0]        ex_opcode_q;
  logic [REG_W-1:0]  ex_rs_q;
  logic [REG_W-1:0]  ex_rt_q;
  logic [REG_W-1:0]  ex_dest_q;
  logic [DATA_W-1:0] ex_rs_val_q;
  logic [DATA_W-1:0] ex_rt_val_q;
  logic [DATA_W-1:0] ex_imm_q;
  logic [DATA_W-1:0] ex_pc_q;

  logic             load_use;
  logic [7:0]       ex_ctrl_d;
  logic [REG_W-1:0] ex_dest_d;
  logic             mul_start_d;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .fsm_idle_i (state_q == IDLE),
    .ex_valid_i (ex_valid_q),
    .ex_ctrl_i  (ex_ctrl_q),
    .ex_dest_i  (ex_dest_q),
    .id_valid_i (bus.id_valid),
    .id_ctrl_i  (bus.id_ctrl),
    .id_rs_i    (bus.id_rs),
    .id_rt_i    (bus.id_rt),
    .load_use_o (load_use)
  );

  assign ex_ctrl_d   = bus.id_valid ? bus.id_ctrl : 8'h00;
  assign ex_dest_d   = bus.id_ctrl[REG_DST] ? bus.id_rd : bus.id_rt;
  assign mul_start_d = bus.id_valid && (bus.id_opcode == OP_MUL) && (MUL_CYCLES > 1);

  // NOTE: all state below uses non-blocking assignment so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_opcode_q <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_dest_q   <= '0;
      ex_rs_val_q <= '0;
      ex_rt_val_q <= '0;
      ex_imm_q    <= '0;
      ex_pc_q     <= '0;
    end else if (bus.flush) begin
      // Kill EX and abort any MUL; the ID instruction is dropped by upstream.
      state_q    <= IDLE;
      cnt_q      <= '0;
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_q <= IDLE;
    end else if (load_use) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_opcode_q <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_dest_q   <= '0;
      ex_rs_val_q <= '0;
      ex_rt_val_q <= '0;
      ex_imm_q    <= '0;
      ex_pc_q     <= '0;
    end else begin
      ex_valid_q  <= bus.id_valid;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_opcode_q <= bus.id_opcode;
      ex_rs_q     <= bus.id_rs;
      ex_rt_q     <= bus.id_rt;
      ex_dest_q   <= ex_dest_d;
      ex_rs_val_q <= bus.id_rs_val;
      ex_rt_val_q <= bus.id_rt_val;
      ex_imm_q    <= bus.id_imm;
      ex_pc_q     <= bus.id_pc;
      if (mul_start_d) begin
        state_q <= BUSY;
        cnt_q   <= MUL_LOAD;
      end
    end
  end

  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_ctrl   = ex_ctrl_q;
  assign bus.ex_opcode = ex_opcode_q;
  assign bus.ex_rs     = ex_rs_q;
  assign bus.ex_rt     = ex_rt_q;
  assign bus.ex_dest   = ex_dest_q;
  assign bus.ex_rs_val = ex_rs_val_q;
  assign bus.ex_rt_val = ex_rt_val_q;
  assign bus.ex_imm    = ex_imm_q;
  assign bus.ex_pc     = ex_pc_q;
  assign bus.ex_busy   = (state_q == BUSY);
  assign bus.stall     = ~reset & ~bus.flush & ((state_q == BUSY) | load_use);
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table covering load-use, MUL
// occupancy and flush, plus hand sequences for datapath and reset-while-busy.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  id_ex_if #(.DATA_W(32), .REG_W(5)) bus ();

  id_ex_stage #(.DATA_W(32), .REG_W(5), .MUL_CYCLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       v;
    logic [5:0] op;
    logic [7:0] ctrl;
    logic [4:0] rs, rt, rd;
    logic       fl;
    logic       e_stall;
    logic       e_v;
    logic [7:0] e_ctrl;
    logic [4:0] e_dest;
    logic       e_busy;
  } vec_t;

  localparam logic [7:0] C_LDW = 8'h36;
  localparam logic [7:0] C_ALU = 8'h82;
  localparam logic [7:0] C_STW = 8'h0C;
  localparam logic [7:0] C_JMP = 8'h41;

  vec_t vecs[22];

  function automatic vec_t mk(logic v, logic [5:0] op, logic [7:0] ctrl,
                              logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic fl,
                              logic e_stall, logic e_v, logic [7:0] e_ctrl,
                              logic [4:0] e_dest, logic e_busy);
    vec_t r;
    r.v = v; r.op = op; r.ctrl = ctrl; r.rs = rs; r.rt = rt; r.rd = rd; r.fl = fl;
    r.e_stall = e_stall; r.e_v = e_v; r.e_ctrl = e_ctrl; r.e_dest = e_dest; r.e_busy = e_busy;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [7:0] ctrl,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic fl);
    bus.id_valid  = v;
    bus.id_opcode = op;
    bus.id_ctrl   = ctrl;
    bus.id_rs     = rs;
    bus.id_rt     = rt;
    bus.id_rd     = rd;
    bus.flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Table rows: inputs held for one cycle; e_stall is sampled before the
    // edge, the remaining expectations just after it.
    vecs[0]  = mk(1, OP_LDW, C_LDW, 1, 5, 0, 0,  0, 1, C_LDW, 5, 0);
    vecs[1]  = mk(1, OP_ADD, C_ALU, 5, 6, 9, 0,  1, 0, 8'h00, 0, 0);
    vecs[2]  = mk(1, OP_ADD, C_ALU, 5, 6, 9, 0,  0, 1, C_ALU, 9, 0);
    vecs[3]  = mk(1, OP_LDW, C_LDW, 2, 0, 0, 0,  0, 1, C_LDW, 0, 0);
    vecs[4]  = mk(1, OP_ADD, C_ALU, 0, 3, 4, 0,  0, 1, C_ALU, 4, 0);
    vecs[5]  = mk(1, OP_MUL, C_ALU, 1, 2, 8, 0,  0, 1, C_ALU, 8, 1);
    vecs[6]  = mk(1, OP_SUB, C_ALU, 3, 4, 10, 0, 1, 1, C_ALU, 8, 1);
    vecs[7]  = mk(1, OP_SUB, C_ALU, 3, 4, 10, 0, 1, 1, C_ALU, 8, 0);
    vecs[8]  = mk(1, OP_SUB, C_ALU, 3, 4, 10, 0, 0, 1, C_ALU, 10, 0);
    vecs[9]  = mk(1, OP_LDW, C_LDW, 1, 7, 0, 0,  0, 1, C_LDW, 7, 0);
    vecs[10] = mk(1, OP_STW, C_STW, 3, 7, 0, 0,  1, 0, 8'h00, 0, 0);
    vecs[11] = mk(1, OP_STW, C_STW, 3, 7, 0, 0,  0, 1, C_STW, 7, 0);
    vecs[12] = mk(1, OP_LDW, C_LDW, 1, 7, 0, 0,  0, 1, C_LDW, 7, 0);
    vecs[13] = mk(1, OP_JUMP, C_JMP, 7, 7, 0, 0, 0, 1, C_JMP, 7, 0);
    vecs[14] = mk(0, OP_LDW, C_LDW, 1, 3, 0, 0,  0, 0, 8'h00, 3, 0);
    vecs[15] = mk(1, OP_MUL, C_ALU, 1, 2, 8, 0,  0, 1, C_ALU, 8, 1);
    vecs[16] = mk(1, OP_SUB, C_ALU, 3, 4, 10, 0, 1, 1, C_ALU, 8, 1);
    vecs[17] = mk(1, OP_SUB, C_ALU, 3, 4, 10, 1, 0, 0, 8'h00, 8, 0);
    vecs[18] = mk(1, OP_SUB, C_ALU, 3, 4, 10, 0, 0, 1, C_ALU, 10, 0);
    vecs[19] = mk(1, OP_LDW, C_LDW, 1, 5, 0, 0,  0, 1, C_LDW, 5, 0);
    vecs[20] = mk(1, OP_ADD, C_ALU, 5, 6, 9, 1,  0, 0, 8'h00, 5, 0);
    vecs[21] = mk(1, OP_ADD, C_ALU, 5, 6, 9, 0,  0, 1, C_ALU, 9, 0);

    reset = 1'b1;
    drive(0, 6'h00, 8'h00, 0, 0, 0, 0);
    bus.id_rs_val = '0;
    bus.id_rt_val = '0;
    bus.id_imm    = '0;
    bus.id_pc     = '0;
    tick();
    tick();
    check("reset_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("reset_ex_ctrl",  32'(bus.ex_ctrl),  32'd0);
    check("reset_ex_dest",  32'(bus.ex_dest),  32'd0);
    check("reset_ex_pc",    bus.ex_pc,         32'd0);
    check("reset_ex_busy",  32'(bus.ex_busy),  32'd0);
    check("reset_stall",    32'(bus.stall),    32'd0);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].fl);
      bus.id_pc     = 32'h0000_1000 + 32'(i * 4);
      bus.id_rs_val = 32'h1000_0000 + 32'(i);
      bus.id_rt_val = 32'h2000_0000 + 32'(i);
      bus.id_imm    = 32'h0000_0100 + 32'(i);
      #1;
      check($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
      tick();
      check($sformatf("v%0d_ex_valid", i), 32'(bus.ex_valid), 32'(vecs[i].e_v));
      check($sformatf("v%0d_ex_ctrl", i),  32'(bus.ex_ctrl),  32'(vecs[i].e_ctrl));
      check($sformatf("v%0d_ex_dest", i),  32'(bus.ex_dest),  32'(vecs[i].e_dest));
      check($sformatf("v%0d_ex_busy", i),  32'(bus.ex_busy),  32'(vecs[i].e_busy));
    end

    // Full datapath capture, then confirm ID changes do not reach EX without an edge.
    drive(1, OP_ADD, C_ALU, 3, 4, 5, 0);
    bus.id_rs_val = 32'hDEAD_BEEF;
    bus.id_rt_val = 32'h1234_5678;
    bus.id_imm    = 32'hFFFF_FF80;
    bus.id_pc     = 32'h0000_0400;
    tick();
    check("dp_opcode", 32'(bus.ex_opcode), 32'(OP_ADD));
    check("dp_rs",     32'(bus.ex_rs),     32'd3);
    check("dp_rt",     32'(bus.ex_rt),     32'd4);
    check("dp_dest",   32'(bus.ex_dest),   32'd5);
    check("dp_rs_val", bus.ex_rs_val,      32'hDEAD_BEEF);
    check("dp_rt_val", bus.ex_rt_val,      32'h1234_5678);
    check("dp_imm",    bus.ex_imm,         32'hFFFF_FF80);
    check("dp_pc",     bus.ex_pc,          32'h0000_0400);
    bus.id_pc     = 32'h0000_0888;
    bus.id_rs_val = 32'h0;
    #2;
    check("dp_no_comb_pc",     bus.ex_pc,     32'h0000_0400);
    check("dp_no_comb_rs_val", bus.ex_rs_val, 32'hDEAD_BEEF);
    @(negedge clk);

    // Reset while a MUL is occupying EX.
    drive(1, OP_MUL, C_ALU, 1, 2, 8, 0);
    tick();
    check("rb_busy_before", 32'(bus.ex_busy), 32'd1);
    reset = 1'b1;
    drive(1, OP_SUB, C_ALU, 3, 4, 10, 0);
    #1;
    check("rb_stall_in_reset", 32'(bus.stall), 32'd0);
    tick();
    check("rb_ex_valid", 32'(bus.ex_valid), 32'd0);
    check("rb_ex_ctrl",  32'(bus.ex_ctrl),  32'd0);
    check("rb_ex_dest",  32'(bus.ex_dest),  32'd0);
    check("rb_ex_pc",    bus.ex_pc,         32'd0);
    check("rb_ex_imm",   bus.ex_imm,        32'd0);
    check("rb_ex_busy",  32'(bus.ex_busy),  32'd0);
    reset = 1'b0;
    #1;
    check("rb_stall_after", 32'(bus.stall), 32'd0);
    tick();
    check("rb_reload_valid", 32'(bus.ex_valid), 32'd1);
    check("rb_reload_dest",  32'(bus.ex_dest),  32'd10);
    check("rb_reload_busy",  32'(bus.ex_busy),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
